race_lap_timer: RTL and testbench

RACE_LAP_TIMER -- requirements
Module: race_lap_timer

---
 rtl/race_lap_timer.sv | 204 ++++++++++++++++++++
 tb/tb_race_lap_timer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/race_lap_timer.sv
// ============================================================================
// Module   : race_lap_timer
// Purpose  : Checkpoint-ordered lap timer with best/last lap capture,
//            pause, lap-count finish and lap-time saturation timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module race_lap_timer #(
  parameter int NUM_CP   = 4,
  parameter int TIME_W   = 16,
  parameter int TICK_DIV = 650000,
  parameter int MAX_TIME = 59999,
  parameter int NUM_LAPS = 3
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [NUM_CP-1:0] cp_hit,
  output logic [TIME_W-1:0] current_lap_time,
  output logic [TIME_W-1:0] last_lap_time,
  output logic [TIME_W-1:0] best_lap_time,
  output logic [3:0]        lap_count,
  output logic [3:0]        next_cp,
  output logic              lap_finished,
  output logic              race_done,
  output logic              max_time_exceeded
);

  localparam int PRESC_W = $clog2(TICK_DIV);

  localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0]  c_max_time   = TIME_W'(MAX_TIME);
  localparam logic [3:0]         c_num_laps   = 4'(NUM_LAPS);
  localparam logic [3:0]         c_last_cp    = 4'(NUM_CP - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_RUNNING  = 3'd2,
    S_PAUSED   = 3'd3,
    S_FINISHED = 3'd4,
    S_TIMEOUT  = 3'd5
  } state_t;

  state_t              r_state,   w_state_nxt;
  logic [PRESC_W-1:0]  r_presc,   w_presc_nxt;
  logic [TIME_W-1:0]   r_cur,     w_cur_nxt;
  logic [TIME_W-1:0]   r_last,    w_last_nxt;
  logic [TIME_W-1:0]   r_best,    w_best_nxt;
  logic [3:0]          r_laps,    w_laps_nxt;
  logic [3:0]          r_next,    w_next_nxt;
  logic                r_lap_fin, w_lap_fin_nxt;
  logic                r_done,    w_done_nxt;
  logic                r_tmo,     w_tmo_nxt;

  logic                w_tick;
  logic                w_hit;
  logic                w_lap;
  logic                w_sat;
  logic [3:0]          w_cp_adv;

  always_comb begin
    w_tick = (r_presc == c_presc_last);
    w_sat  = w_tick && (r_cur == c_max_time);

    // Only the expected checkpoint's strobe matters; others are ignored.
    w_hit = 1'b0;
    for (int i = 0; i < NUM_CP; i++) begin
      if (r_next == 4'(i)) begin
        w_hit = cp_hit[i];
      end
    end
    w_lap    = w_hit && (r_next == 4'd0);
    w_cp_adv = (r_next == c_last_cp) ? 4'd0 : r_next + 4'd1;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_presc_nxt   = r_presc;
    w_cur_nxt     = r_cur;
    w_last_nxt    = r_last;
    w_best_nxt    = r_best;
    w_laps_nxt    = r_laps;
    w_next_nxt    = r_next;
    w_lap_fin_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ARMED;
        end
      end

      S_ARMED: begin
        if (cp_hit[0]) begin
          w_state_nxt = S_RUNNING;
          w_presc_nxt = '0;
          w_cur_nxt   = '0;
          w_next_nxt  = 4'd1;
        end
      end

      S_RUNNING: begin
        if (w_lap) begin
          // A tick landing on the lap edge is dropped: capture the pre-tick time.
          w_last_nxt    = r_cur;
          w_best_nxt    = (r_cur < r_best) ? r_cur : r_best;
          w_cur_nxt     = '0;
          w_presc_nxt   = '0;
          w_laps_nxt    = r_laps + 4'd1;
          w_next_nxt    = 4'd1;
          w_lap_fin_nxt = 1'b1;
          if (r_laps + 4'd1 == c_num_laps) begin
            w_state_nxt = S_FINISHED;
          end else if (stop) begin
            w_state_nxt = S_PAUSED;
          end
        end else begin
          w_presc_nxt = w_tick ? '0 : r_presc + PRESC_W'(1);
          if (w_tick && !w_sat) begin
            w_cur_nxt = r_cur + TIME_W'(1);
          end
          if (w_hit) begin
            w_next_nxt = w_cp_adv;
          end
          if (w_sat) begin
            w_state_nxt = S_TIMEOUT;
          end else if (stop) begin
            w_state_nxt = S_PAUSED;
          end
        end
      end

      S_PAUSED: begin
        if (!stop) begin
          w_state_nxt = S_RUNNING;
        end
      end

      S_FINISHED, S_TIMEOUT: begin
        if (!start) begin
          w_state_nxt = S_IDLE;
          w_presc_nxt = '0;
          w_cur_nxt   = '0;
          w_laps_nxt  = 4'd0;
          w_next_nxt  = 4'd0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_done_nxt = (w_state_nxt == S_FINISHED);
    w_tmo_nxt  = (w_state_nxt == S_TIMEOUT);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_presc   <= '0;
      r_cur     <= '0;
      r_last    <= '0;
      r_best    <= '1;
      r_laps    <= 4'd0;
      r_next    <= 4'd0;
      r_lap_fin <= 1'b0;
      r_done    <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_presc   <= w_presc_nxt;
      r_cur     <= w_cur_nxt;
      r_last    <= w_last_nxt;
      r_best    <= w_best_nxt;
      r_laps    <= w_laps_nxt;
      r_next    <= w_next_nxt;
      r_lap_fin <= w_lap_fin_nxt;
      r_done    <= w_done_nxt;
      r_tmo     <= w_tmo_nxt;
    end
  end

  assign current_lap_time  = r_cur;
  assign last_lap_time     = r_last;
  assign best_lap_time     = r_best;
  assign lap_count         = r_laps;
  assign next_cp           = r_next;
  assign lap_finished      = r_lap_fin;
  assign race_done         = r_done;
  assign max_time_exceeded = r_tmo;

endmodule

`default_nettype wire

// File: tb/tb_race_lap_timer.sv
// ============================================================================
// Module   : tb_race_lap_timer
// Purpose  : Self-checking bench for race_lap_timer (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_race_lap_timer;

  localparam int NUM_CP   = 3;
  localparam int TIME_W   = 16;
  localparam int TICK_DIV = 4;
  localparam int MAX_TIME = 100;
  localparam int NUM_LAPS = 2;

  localparam int P_IDLE = 0, P_ARMED = 1, P_RUN = 2, P_PAUSE = 3, P_FIN = 4, P_TMO = 5;

  logic              pclk = 1'b0;
  logic              rst  = 1'b1;
  logic              start = 1'b0;
  logic              stop  = 1'b0;
  logic [NUM_CP-1:0] cp_hit = '0;
  logic [TIME_W-1:0] current_lap_time, last_lap_time, best_lap_time;
  logic [3:0]        lap_count, next_cp;
  logic              lap_finished, race_done, max_time_exceeded;

  int n_checks = 0;
  int n_fail   = 0;

  race_lap_timer #(
    .NUM_CP(NUM_CP), .TIME_W(TIME_W), .TICK_DIV(TICK_DIV),
    .MAX_TIME(MAX_TIME), .NUM_LAPS(NUM_LAPS)
  ) dut (
    .pclk(pclk), .rst(rst), .start(start), .stop(stop), .cp_hit(cp_hit),
    .current_lap_time(current_lap_time), .last_lap_time(last_lap_time),
    .best_lap_time(best_lap_time), .lap_count(lap_count), .next_cp(next_cp),
    .lap_finished(lap_finished), .race_done(race_done),
    .max_time_exceeded(max_time_exceeded)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: lap time is simply running cycles in this lap / TICK_DIV.
  int m_phase = P_IDLE;
  int m_run   = 0;
  int m_last  = 0;
  int m_best  = 16'hFFFF;
  int m_laps  = 0;
  int m_next  = 0;
  bit m_lf    = 1'b0;

  always @(posedge pclk or negedge rst) begin
    if (!rst) begin
      m_phase = P_IDLE; m_run = 0; m_last = 0; m_best = 16'hFFFF;
      m_laps = 0; m_next = 0; m_lf = 1'b0;
    end else begin
      m_lf = 1'b0;
      case (m_phase)
        P_IDLE:  if (start) m_phase = P_ARMED;
        P_ARMED: if (cp_hit[0]) begin m_phase = P_RUN; m_run = 0; m_next = 1; end
        P_RUN: begin
          if (m_next == 0 && cp_hit[0]) begin
            m_last = m_run / TICK_DIV;
            if (m_last < m_best) m_best = m_last;
            m_run = 0; m_laps++; m_next = 1; m_lf = 1'b1;
            if (m_laps == NUM_LAPS) m_phase = P_FIN;
            else if (stop) m_phase = P_PAUSE;
          end else begin
            if (cp_hit[m_next]) m_next = (m_next == NUM_CP - 1) ? 0 : m_next + 1;
            if ((m_run + 1) / TICK_DIV > MAX_TIME) m_phase = P_TMO;
            else begin
              m_run++;
              if (stop) m_phase = P_PAUSE;
            end
          end
        end
        P_PAUSE: if (!stop) m_phase = P_RUN;
        default: if (!start) begin m_phase = P_IDLE; m_run = 0; m_laps = 0; m_next = 0; end
      endcase
    end
  end

  always @(negedge pclk) begin
    if (rst) begin
      chk("current_lap_time", 32'(current_lap_time), (m_phase == P_TMO) ? MAX_TIME : m_run / TICK_DIV);
      chk("last_lap_time", 32'(last_lap_time), m_last);
      chk("best_lap_time", 32'(best_lap_time), m_best);
      chk("lap_count", 32'(lap_count), m_laps);
      chk("next_cp", 32'(next_cp), m_next);
      chk("lap_finished", 32'(lap_finished), 32'(m_lf));
      chk("race_done", 32'(race_done), 32'(m_phase == P_FIN));
      chk("max_time_exceeded", 32'(max_time_exceeded), 32'(m_phase == P_TMO));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic hit(input logic [NUM_CP-1:0] v);
    cp_hit = v;
    @(negedge pclk);
    cp_hit = '0;
  endtask

  // Assumes the lap started at run=0; captures n ticks.
  task automatic do_lap(input int n);
    cyc(TICK_DIV * n - 2);
    hit(3'b010);
    hit(3'b100);
    hit(3'b001);
  endtask

  task automatic arm();
    start = 1'b1;
    cyc(1);
    hit(3'b001);
  endtask

  initial begin
    #1 rst = 1'b0;
    cyc(2);
    chk("rst_cur", 32'(current_lap_time), 0);
    chk("rst_best", 32'(best_lap_time), 32'hFFFF);
    chk("rst_next", 32'(next_cp), 0);
    rst = 1'b1;

    // Arm and time
    arm();
    cyc(40);
    chk("arm_cur10", 32'(current_lap_time), 10);
    chk("arm_next1", 32'(next_cp), 1);

    // Lap order
    hit(3'b010); hit(3'b100); hit(3'b001);
    chk("lap1_pulse", 32'(lap_finished), 1);
    chk("lap1_count", 32'(lap_count), 1);
    chk("lap1_last", 32'(last_lap_time), 10);
    chk("lap1_best", 32'(best_lap_time), 10);
    cyc(1);
    chk("lap1_pulse_end", 32'(lap_finished), 0);
    hit(3'b100); hit(3'b001);
    chk("ooo_count", 32'(lap_count), 1);
    chk("ooo_next", 32'(next_cp), 1);
    do_lap(8);
    chk("fin_last", 32'(last_lap_time), 8);
    chk("fin_best", 32'(best_lap_time), 8);
    chk("fin_done", 32'(race_done), 1);
    chk("fin_count", 32'(lap_count), 2);
    start = 1'b0;
    cyc(1);
    chk("idle_count", 32'(lap_count), 0);
    chk("idle_best_kept", 32'(best_lap_time), 8);

    // Best/last: 12 then 8 after reset, then 8 then 12
    rst = 1'b0; cyc(1); rst = 1'b1;
    arm(); do_lap(12);
    chk("r2_last12", 32'(last_lap_time), 12);
    do_lap(8);
    chk("r2_last8", 32'(last_lap_time), 8);
    chk("r2_best8", 32'(best_lap_time), 8);
    start = 1'b0; cyc(1);
    arm(); do_lap(8); do_lap(12);
    chk("r3_last12", 32'(last_lap_time), 12);
    chk("r3_best8", 32'(best_lap_time), 8);
    chk("r3_done", 32'(race_done), 1);
    start = 1'b0; cyc(1);

    // Pause, then lap hit on a tick cycle
    arm();
    cyc(10);
    stop = 1'b1;
    cyc(1);
    cp_hit = 3'b010;
    cyc(19);
    chk("pause_cur", 32'(current_lap_time), 2);
    chk("pause_next", 32'(next_cp), 1);
    stop = 1'b0; cp_hit = '0;
    cyc(1);
    hit(3'b010); hit(3'b100);
    cyc(2);
    hit(3'b001);
    chk("tick_lap_last", 32'(last_lap_time), 3);

    // Mid-race reset
    cyc(5);
    #2 rst = 1'b0;
    #1;
    chk("mrst_cur", 32'(current_lap_time), 0);
    chk("mrst_last", 32'(last_lap_time), 0);
    chk("mrst_best", 32'(best_lap_time), 32'hFFFF);
    chk("mrst_count", 32'(lap_count), 0);
    @(negedge pclk);
    start = 1'b0; rst = 1'b1;
    hit(3'b001);
    cyc(2);
    chk("mrst_needs_start", 32'(next_cp), 0);

    // Timeout
    arm();
    cyc(420);
    chk("tmo_cur", 32'(current_lap_time), 100);
    chk("tmo_flag", 32'(max_time_exceeded), 1);
    cyc(20);
    chk("tmo_hold", 32'(current_lap_time), 100);
    start = 1'b0; cyc(1);
    chk("tmo_exit", 32'(max_time_exceeded), 0);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 19) != 0);
      stop  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) cp_hit = 3'($urandom);
      else if ($urandom_range(0, 2) == 0) cp_hit = 3'(1 << $urandom_range(0, 2));
      else cp_hit = '0;
      rst = ($urandom_range(0, 999) != 0);
      @(negedge pclk);
    end
    rst = 1'b1; cp_hit = '0; stop = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
